// File: rtl/mysystem_pio_edge.sv
// -----------------------------------------------------------------------------
// mysystem_pio_edge
//
// Avalon-MM parallel I/O port with edge-capture interrupt.
//
// Output side: a WIDTH-bit data_out register that drives out_port directly.
// It can be written whole (address 1), bit-set (address 4) or bit-cleared
// (address 5).
//
// Input side: in_port is synchronised through two flops (s1, s2). A history
// flop (s3) follows them. Edges between s2 and s3 are latched into
// edge_capture. The EDGE_TYPE parameter selects which edges count:
// 0 rising, 1 falling, 2 any.
//
// Software clears captured bits with a write-1-to-clear to address 3.
// irq is the OR of (edge_capture & irq_mask).
//
// Parameters
//   WIDTH        port width, 1..32
//   RESET_VALUE  data_out value after reset (low WIDTH bits used)
//   EDGE_TYPE    0 rising, 1 falling, 2 any edge
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   address      register select (0..7)
//   chipselect   slave select
//   write_n      write strobe, active-low
//   writedata    write data, bits [WIDTH-1:0] used
//   in_port      asynchronous external inputs
//   out_port     data_out register contents
//   readdata     combinational read mux, zero above WIDTH
//   irq          level interrupt, active-high
//
// Address map
//   0  synchronised input (read only)
//   1  data_out (read/write)
//   2  irq_mask (read/write)
//   3  edge_capture (read, write-1-to-clear)
//   4  outset (write only)
//   5  outclear (write only)
//   6-7 reserved
// -----------------------------------------------------------------------------
module mysystem_pio_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RESET_DATA = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] data_out_reg,     data_out_next;
    logic [WIDTH-1:0] irq_mask_reg,     irq_mask_next;
    logic [WIDTH-1:0] edge_capture_reg, edge_capture_next;
    logic [WIDTH-1:0] s1_reg, s2_reg, s3_reg;

    logic [WIDTH-1:0] edge_detect;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] read_value;
    logic             write_strobe;

    // Upper writedata bits are ignored for narrow ports.
    // They are folded into a deliberately unused signal.
    logic unused_writedata;
    assign unused_writedata = |writedata;

    assign wdata        = writedata[WIDTH-1:0];
    assign write_strobe = chipselect & ~write_n;

    // -------------------------------------------------------------------------
    // Per-bit edge detection on the synchronised input vs. its history flop
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == 0) begin : g_rise
                assign edge_detect[gi] = s2_reg[gi] & ~s3_reg[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign edge_detect[gi] = ~s2_reg[gi] & s3_reg[gi];
            end else begin : g_any
                assign edge_detect[gi] = s2_reg[gi] ^ s3_reg[gi];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Register write decode
    // -------------------------------------------------------------------------
    always_comb begin
        data_out_next = data_out_reg;
        irq_mask_next = irq_mask_reg;
        clear_mask    = '0;
        if (write_strobe) begin
            case (address)
                3'd1:    data_out_next = wdata;
                3'd2:    irq_mask_next = wdata;
                3'd3:    clear_mask    = wdata;
                3'd4:    data_out_next = data_out_reg | wdata;
                3'd5:    data_out_next = data_out_reg & ~wdata;
                default: ;
            endcase
        end
        // The clear is applied first and the new edges are OR-ed in afterwards.
        // A bit that is cleared and sees a fresh edge in the same cycle
        // therefore stays set.
        edge_capture_next = (edge_capture_reg & ~clear_mask) | edge_detect;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg     <= RESET_DATA;
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
            s1_reg           <= '0;
            s2_reg           <= '0;
            s3_reg           <= '0;
        end else begin
            data_out_reg     <= data_out_next;
            irq_mask_reg     <= irq_mask_next;
            edge_capture_reg <= edge_capture_next;
            s1_reg           <= in_port;
            s2_reg           <= s1_reg;
            s3_reg           <= s2_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        read_value = '0;
        case (address)
            3'd0:    read_value = s2_reg;
            3'd1:    read_value = data_out_reg;
            3'd2:    read_value = irq_mask_reg;
            3'd3:    read_value = edge_capture_reg;
            default: read_value = '0;
        endcase
    end

    always_comb begin
        readdata            = '0;
        readdata[WIDTH-1:0] = read_value;
    end

    assign out_port = data_out_reg;
    assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule
